// File: rtl/systolic_array.sv
// rtl/systolic_array.sv - weight-stationary NxN systolic matrix-vector engine with internal skew/deskew
module systolic_array #(
    parameter int ACT_WIDTH      = 8,
    parameter int WGT_WIDTH      = 8,
    parameter int MULT_OUT_WIDTH = ACT_WIDTH + WGT_WIDTH,
    parameter int PE_OUT_WIDTH   = 32,
    parameter int OP_SIG_WIDTH   = 3,
    parameter int ARRAY_SIZE     = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [ACT_WIDTH*ARRAY_SIZE-1:0]         act_data_in,
    input  logic [WGT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] wgt_data_in,
    output logic [PE_OUT_WIDTH*ARRAY_SIZE-1:0]      result_data_out
);

    localparam int N = ARRAY_SIZE;

    logic [ACT_WIDTH-1:0]      row_act  [N];
    logic [ACT_WIDTH-1:0]      a_in     [N][N];
    logic [ACT_WIDTH-1:0]      a_q      [N][N];
    logic [PE_OUT_WIDTH-1:0]   psum_in  [N][N];
    logic [PE_OUT_WIDTH-1:0]   psum_q   [N][N];
    logic [MULT_OUT_WIDTH-1:0] prod     [N][N];

    // Op-select width is reserved; nothing is generated from it yet.
    if (OP_SIG_WIDTH < 0) begin : g_op_sig_reserved
    end

    // Row r is delayed r cycles so its activation meets the psum wavefront.
    for (genvar r = 0; r < N; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign row_act[r] = act_data_in[0 +: ACT_WIDTH];
        end else begin : g_delay
            logic [ACT_WIDTH-1:0] sr [r];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= act_data_in[r*ACT_WIDTH +: ACT_WIDTH];
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign row_act[r] = sr[r-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [WGT_WIDTH-1:0] w;
            assign w = wgt_data_in[(r*N+c)*WGT_WIDTH +: WGT_WIDTH];

            if (c == 0) begin : g_a_edge
                assign a_in[r][c] = row_act[r];
            end else begin : g_a_link
                assign a_in[r][c] = a_q[r][c-1];
            end

            if (r == 0) begin : g_p_edge
                assign psum_in[r][c] = '0;
            end else begin : g_p_link
                assign psum_in[r][c] = psum_q[r-1][c];
            end

            assign prod[r][c] = MULT_OUT_WIDTH'(a_in[r][c]) * MULT_OUT_WIDTH'(w);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c]    <= '0;
                    psum_q[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c]    <= a_in[r][c];
                    psum_q[r][c] <= psum_in[r][c] + PE_OUT_WIDTH'(prod[r][c]);
                end
            end
        end
    end

    // Column c finishes N-1-c cycles early; pad it so all columns leave together.
    for (genvar c = 0; c < N; c++) begin : g_deskew
        localparam int D = N - 1 - c;
        if (D == 0) begin : g_direct
            assign result_data_out[c*PE_OUT_WIDTH +: PE_OUT_WIDTH] = psum_q[N-1][c];
        end else begin : g_delay
            logic [PE_OUT_WIDTH-1:0] sr [D];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < D; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= psum_q[N-1][c];
                    for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
                end
            end
            assign result_data_out[c*PE_OUT_WIDTH +: PE_OUT_WIDTH] = sr[D-1];
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// tb/tb_systolic_array.sv - scoreboard bench for systolic_array (N=2/32-bit and N=4/16-bit instances)
module tb_systolic_array;

    localparam int AW = 8;
    localparam int WW = 8;
    localparam int N2 = 2;
    localparam int P2 = 32;
    localparam int N4 = 4;
    localparam int P4 = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [AW*N2-1:0]      act2;
    logic [WW*N2*N2-1:0]   wgt2;
    logic [P2*N2-1:0]      res2;
    logic [AW*N4-1:0]      act4;
    logic [WW*N4*N4-1:0]   wgt4;
    logic [P4*N4-1:0]      res4;

    always #5 clk = ~clk;

    systolic_array #(
        .ACT_WIDTH(AW), .WGT_WIDTH(WW), .MULT_OUT_WIDTH(AW+WW),
        .PE_OUT_WIDTH(P2), .OP_SIG_WIDTH(3), .ARRAY_SIZE(N2)
    ) dut2 (
        .clk(clk), .reset(reset),
        .act_data_in(act2), .wgt_data_in(wgt2), .result_data_out(res2)
    );

    systolic_array #(
        .ACT_WIDTH(AW), .WGT_WIDTH(WW), .MULT_OUT_WIDTH(AW+WW),
        .PE_OUT_WIDTH(P4), .OP_SIG_WIDTH(3), .ARRAY_SIZE(N4)
    ) dut4 (
        .clk(clk), .reset(reset),
        .act_data_in(act4), .wgt_data_in(wgt4), .result_data_out(res4)
    );

    int w2 [4][4];
    int w4 [4][4];
    logic [P2*N2-1:0] q2 [$];
    logic [P4*N4-1:0] q4 [$];
    logic [P2*N2-1:0] e2;
    logic [P4*N4-1:0] e4;
    int total = 0;
    int bad   = 0;

    // y[c] = sum_r x[r]*W[r][c], reduced modulo 2^pw
    function automatic logic [127:0] mv(input int n, input int pw, input int x[4], input int w[4][4]);
        logic [127:0] y;
        longint unsigned acc;
        y = '0;
        for (int c = 0; c < n; c++) begin
            acc = 0;
            for (int r = 0; r < n; r++) acc += 64'(x[r]) * 64'(w[r][c]);
            acc = acc % (64'd1 << pw);
            y = y | (128'(acc) << (c * pw));
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic drive(input int x2[4], input int x4[4]);
        logic [127:0] e;
        for (int r = 0; r < N2; r++) act2[r*AW +: AW] = AW'(x2[r]);
        for (int r = 0; r < N4; r++) act4[r*AW +: AW] = AW'(x4[r]);
        for (int r = 0; r < N2; r++)
            for (int c = 0; c < N2; c++) wgt2[(r*N2+c)*WW +: WW] = WW'(w2[r][c]);
        for (int r = 0; r < N4; r++)
            for (int c = 0; c < N4; c++) wgt4[(r*N4+c)*WW +: WW] = WW'(w4[r][c]);
        e = mv(N2, P2, x2, w2);
        q2.push_back(e[P2*N2-1:0]);
        e = mv(N4, P4, x4, w4);
        q4.push_back(e[P4*N4-1:0]);
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int z[4] = '{default: 0};
        repeat (2*N4-1) drive(z, z);
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        act2  = '0;
        act4  = '0;
        #1;
        chk("async_reset_n2", 128'(res2), '0);
        chk("async_reset_n4", 128'(res4), '0);
        q2.delete();
        q4.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2*N2-1) q2.push_back('0);
        repeat (2*N4-1) q4.push_back('0);
    endtask

    // Monitor: one expected vector per clock after reset release.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_reset_n2", 128'(res2), '0);
            chk("in_reset_n4", 128'(res4), '0);
        end else begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_empty_n2: got %h want queued value", res2);
            end else begin
                e2 = q2.pop_front();
                chk("stream_n2", 128'(res2), 128'(e2));
            end
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_empty_n4: got %h want queued value", res4);
            end else begin
                e4 = q4.pop_front();
                chk("stream_n4", 128'(res4), 128'(e4));
            end
        end
    end

    initial begin
        int z[4]   = '{default: 0};
        int xa[4];
        int xb[4];
        int xc[4];
        reset = 1'b0;
        act2  = '0;
        act4  = '0;
        wgt2  = '0;
        wgt4  = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                w2[r][c] = 0;
                w4[r][c] = 0;
            end
        @(posedge clk);
        #2;
        chk("reset_state_n2", 128'(res2), '0);
        chk("reset_state_n4", 128'(res4), '0);
        reset_pulse();

        w2[0][0] = 1; w2[0][1] = 2; w2[1][0] = 3; w2[1][1] = 4;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) w4[r][c] = (r == c) ? 1 : 0;
        drain();

        xa = '{1, 2, 0, 0};
        xb = '{1, 2, 3, 4};
        xc = '{5, 6, 7, 8};
        drive(xa, xb);
        drive(z, xc);
        drive(z, z);
        chk("single_vec_7_10", 128'(res2), 128'({32'd10, 32'd7}));
        drain();

        xb = '{3, 4, 0, 0};
        drive(xa, z);
        drive(xb, z);
        drive(z, z);
        chk("b2b_first_7_10", 128'(res2), 128'({32'd10, 32'd7}));
        drive(z, z);
        chk("b2b_second_15_22", 128'(res2), 128'({32'd22, 32'd15}));
        drain();

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                w2[r][c] = 255;
                w4[r][c] = 255;
            end
        drain();
        xa = '{255, 255, 255, 255};
        drive(xa, xa);
        drive(z, z);
        drive(z, z);
        chk("max_130050", 128'(res2), 128'({32'd130050, 32'd130050}));
        drain();

        w2[0][0] = 1; w2[0][1] = 2; w2[1][0] = 3; w2[1][1] = 4;
        drain();
        xa = '{1, 2, 1, 1};
        xb = '{3, 4, 2, 2};
        xc = '{5, 6, 3, 3};
        drive(xa, xa);
        drive(xb, xb);
        drive(xc, xc);
        reset_pulse();
        drain();

        for (int blk = 0; blk < 4; blk++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    w2[r][c] = int'($urandom_range(0, 255));
                    w4[r][c] = int'($urandom_range(0, 255));
                end
            drain();
            for (int v = 0; v < 20; v++) begin
                for (int i = 0; i < 4; i++) begin
                    xa[i] = int'($urandom_range(0, 255));
                    xb[i] = (v % 5 == 4) ? 0 : int'($urandom_range(0, 255));
                end
                drive(xa, xb);
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
